adder_1bit_full: RTL and testbench

//  1-bit full adder: sum and carry-out of two operand bits plus carry-in.

---
 rtl/adder_1bit_full.sv | 75 +++++++
 tb/tb_adder_1bit_full.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_1bit_full.sv
// 1-bit full adder leaf cell with generate/propagate taps and an optional registered result.
// Latency: comb ports 0 cycles; registered ports 1 cycle when P_REG_OUT=1, 0 cycles when bypassed.
// Backpressure: none; i_vld qualifies capture, and the registered result holds while i_vld is low.
module adder_1bit_full #(
  parameter bit P_REG_OUT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_num_a,
  input  logic i_num_b,
  input  logic i_cry,
  input  logic i_vld,
  output logic o_res,
  output logic o_cry,
  output logic o_gen,
  output logic o_prp,
  output logic o_res_q,
  output logic o_cry_q,
  output logic o_vld_q
);

  logic gen;
  logic prp;
  logic res;
  logic cry;

  // Generate/propagate form the carry so chained lookahead logic sees the same terms.
  always_comb begin
    gen = i_num_a & i_num_b;
    prp = i_num_a ^ i_num_b;
    res = prp ^ i_cry;
    cry = gen | (i_cry & prp);
  end

  assign o_res = res;
  assign o_cry = cry;
  assign o_gen = gen;
  assign o_prp = prp;

  generate
    if (P_REG_OUT) begin : g_reg
      logic res_q;
      logic cry_q;
      logic vld_q;

      // Valid tracks i_vld every edge; the result is captured only on a valid cycle.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          res_q <= 1'b0;
          cry_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= i_vld;
          if (i_vld) begin
            res_q <= res;
            cry_q <= cry;
          end
        end
      end

      assign o_res_q = res_q;
      assign o_cry_q = cry_q;
      assign o_vld_q = vld_q;
    end else begin : g_bypass
      // Clock and reset have no function in the bypass build.
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst_n;

      assign o_res_q = res;
      assign o_cry_q = cry;
      assign o_vld_q = i_vld;
    end
  endgenerate

endmodule

// File: tb/tb_adder_1bit_full.sv
// Directed bench for adder_1bit_full: registered build (u_reg) and bypass build (u_byp).
// Latency: checks comb outputs 1 ns after drive, registered outputs at the falling edge after capture.
// Backpressure: not applicable; i_vld low exercises the hold behaviour.
module tb_adder_1bit_full;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic c;
  logic vld;

  logic r_res, r_cry, r_gen, r_prp, r_res_q, r_cry_q, r_vld_q;
  logic p_res, p_cry, p_gen, p_prp, p_res_q, p_cry_q, p_vld_q;

  int checks;
  int failures;

  adder_1bit_full #(.P_REG_OUT(1'b1)) u_reg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_num_a (a),
    .i_num_b (b),
    .i_cry   (c),
    .i_vld   (vld),
    .o_res   (r_res),
    .o_cry   (r_cry),
    .o_gen   (r_gen),
    .o_prp   (r_prp),
    .o_res_q (r_res_q),
    .o_cry_q (r_cry_q),
    .o_vld_q (r_vld_q)
  );

  adder_1bit_full #(.P_REG_OUT(1'b0)) u_byp (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_num_a (a),
    .i_num_b (b),
    .i_cry   (c),
    .i_vld   (vld),
    .o_res   (p_res),
    .o_cry   (p_cry),
    .o_gen   (p_gen),
    .o_prp   (p_prp),
    .o_res_q (p_res_q),
    .o_cry_q (p_cry_q),
    .o_vld_q (p_vld_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1;
    a = 1'b1; b = 1'b1; c = 1'b1; vld = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_regs got=%b exp=000", {r_res_q, r_cry_q, r_vld_q});
    end
    // Held in reset across edges with valid input present.
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b000) begin
      failures++;
      $display("FAIL reset_held_regs got=%b exp=000", {r_res_q, r_cry_q, r_vld_q});
    end
    checks++;
    if ({r_cry, r_res} !== 2'b11) begin
      failures++;
      $display("FAIL reset_comb_live got=%b exp=11", {r_cry, r_res});
    end
    vld = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
  endtask

  task automatic test_sum_sweep();
    // Vectors ordered A,B,Cin = 000,010,100,110,001,011,101,111.
    logic [2:0] vec [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    logic [7:0] exp_sum = 8'b1001_0110; // bit i = sum of vec[i]
    logic [7:0] exp_cry = 8'b1110_1000; // bit i = carry of vec[i]
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {a, b, c} = vec[i];
      vld = i[0];
      #1;
      checks++;
      if (r_res !== exp_sum[i]) begin
        failures++;
        $display("FAIL sweep_sum abc=%b got=%b exp=%b", vec[i], r_res, exp_sum[i]);
      end
      checks++;
      if (r_cry !== exp_cry[i]) begin
        failures++;
        $display("FAIL sweep_cry abc=%b got=%b exp=%b", vec[i], r_cry, exp_cry[i]);
      end
      checks++;
      if ({p_res_q, p_cry_q, p_vld_q} !== {exp_sum[i], exp_cry[i], i[0]}) begin
        failures++;
        $display("FAIL bypass_regs abc=%b got=%b exp=%b", vec[i],
                 {p_res_q, p_cry_q, p_vld_q}, {exp_sum[i], exp_cry[i], i[0]});
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_gen_prp();
    @(negedge clk);
    a = 1'b1; b = 1'b1; c = 1'b0;
    #1;
    checks++;
    if ({r_gen, r_prp} !== 2'b10) begin
      failures++;
      $display("FAIL gen_prp_110 got=%b exp=10", {r_gen, r_prp});
    end
    for (int k = 0; k < 2; k++) begin
      a = 1'b1; b = 1'b0; c = k[0];
      #1;
      checks++;
      if ({r_gen, r_prp} !== 2'b01) begin
        failures++;
        $display("FAIL gen_prp_10%0d got=%b exp=01", k, {r_gen, r_prp});
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n = 1'b1;
    vld = 1'b1;
    a = 1'b1; b = 1'b1; c = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b111) begin
      failures++;
      $display("FAIL reg_capture_111 got=%b exp=111", {r_res_q, r_cry_q, r_vld_q});
    end
  endtask

  task automatic test_hold();
    vld = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b110) begin
      failures++;
      $display("FAIL reg_hold got=%b exp=110", {r_res_q, r_cry_q, r_vld_q});
    end
    checks++;
    if ({r_cry, r_res} !== 2'b00) begin
      failures++;
      $display("FAIL hold_comb got=%b exp=00", {r_cry, r_res});
    end
    // Capture a different value (A=1,B=0,Cin=0 -> sum 1, carry 0) to leave state nonzero.
    vld = 1'b1;
    a = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b101) begin
      failures++;
      $display("FAIL reg_capture_100 got=%b exp=101", {r_res_q, r_cry_q, r_vld_q});
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset_midcycle got=%b exp=000", {r_res_q, r_cry_q, r_vld_q});
    end
    a = 1'b0; b = 1'b1; c = 1'b1;
    #1;
    checks++;
    if ({r_cry, r_res} !== 2'b10) begin
      failures++;
      $display("FAIL async_reset_comb got=%b exp=10", {r_cry, r_res});
    end
    // Release between edges; the first edge after release captures 011.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b000) begin
      failures++;
      $display("FAIL release_before_edge got=%b exp=000", {r_res_q, r_cry_q, r_vld_q});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({r_res_q, r_cry_q, r_vld_q} !== 3'b011) begin
      failures++;
      $display("FAIL release_first_edge got=%b exp=011", {r_res_q, r_cry_q, r_vld_q});
    end
    vld = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Consecutive valid cycles: each edge captures the vector applied just before it.
    logic [2:0] vec [3] = '{3'b101, 3'b010, 3'b111};
    logic [1:0] exp [3] = '{2'b10, 2'b01, 2'b11}; // {carry,sum}
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {a, b, c} = vec[i];
      vld = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({r_cry_q, r_res_q, r_vld_q} !== {exp[i], 1'b1}) begin
        failures++;
        $display("FAIL back_to_back abc=%b got=%b exp=%b", vec[i],
                 {r_cry_q, r_res_q, r_vld_q}, {exp[i], 1'b1});
      end
    end
    vld = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sum_sweep();
    test_gen_prp();
    test_registered();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
